// File: rtl/insn_buffer_mw_pkg.sv
// Shared types and default sizes for the multi-wide fetch-to-dispatch instruction buffer.
package insn_buffer_mw_pkg;

    localparam int IBUFFER_SZ     = 16;
    localparam int FETCH_WIDTH    = 2;
    localparam int DISPATCH_WIDTH = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } IF_IB_PACKET;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } IB_DP_PACKET;

    function automatic IB_DP_PACKET to_dp(input IF_IB_PACKET p);
        IB_DP_PACKET d;
        d.valid = p.valid;
        d.pc    = p.pc;
        d.inst  = p.inst;
        return d;
    endfunction

endpackage

// File: rtl/insn_buffer_mw_if.sv
// Fetch/dispatch-facing bundle of the instruction buffer; slave = buffer, master = fetch/dispatch side.
interface insn_buffer_mw_if
    import insn_buffer_mw_pkg::*;
#(
    parameter int DEPTH = IBUFFER_SZ,
    parameter int ENQ_W = FETCH_WIDTH,
    parameter int DEQ_W = DISPATCH_WIDTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DC_W  = $clog2(DEQ_W + 1);

    logic                    squash_in;
    IF_IB_PACKET [ENQ_W-1:0] if_ib_packets;
    logic [DC_W-1:0]         dispatch_cnt;
    logic                    ib_enq_ready;
    logic [CNT_W-1:0]        ib_free;
    logic [CNT_W-1:0]        ib_count;
    logic                    ib_empty;
    logic                    ib_full;
    IB_DP_PACKET [DEQ_W-1:0] ib_dp_packets;

    modport master (
        output squash_in, if_ib_packets, dispatch_cnt,
        input  ib_enq_ready, ib_free, ib_count, ib_empty, ib_full, ib_dp_packets
    );

    modport slave (
        input  squash_in, if_ib_packets, dispatch_cnt,
        output ib_enq_ready, ib_free, ib_count, ib_empty, ib_full, ib_dp_packets
    );

endinterface

// File: rtl/insn_buffer_mw_popcount_prefix.sv
// Counts set lanes of a valid vector and reports whether they form a contiguous prefix from lane 0.
module popcount_prefix
    import insn_buffer_mw_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0]             vld_i,
    output logic [$clog2(W+1)-1:0]   cnt_o,
    output logic                     contig_o
);
    localparam int CW = $clog2(W + 1);

    logic seen_gap;

    always_comb begin
        cnt_o    = '0;
        contig_o = 1'b1;
        seen_gap = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (vld_i[i]) begin
                cnt_o = cnt_o + CW'(1);
                if (seen_gap) contig_o = 1'b0;
            end else begin
                seen_gap = 1'b1;
            end
        end
    end

endmodule

// File: rtl/insn_buffer_mw.sv
// Multi-wide instruction FIFO: up to ENQ_W packets in from fetch, DEQ_W oldest presented to dispatch.
// Ready depends only on registered occupancy, so fetch throttling has no path from dispatch_cnt.
module insn_buffer_mw
    import insn_buffer_mw_pkg::*;
#(
    parameter int DEPTH = IBUFFER_SZ,
    parameter int ENQ_W = FETCH_WIDTH,
    parameter int DEQ_W = DISPATCH_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    insn_buffer_mw_if.slave ib
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int EC_W  = $clog2(ENQ_W + 1);
    localparam int DC_W  = $clog2(DEQ_W + 1);

    IB_DP_PACKET      mem_q [DEPTH];
    IB_DP_PACKET      mem_d [DEPTH];
    logic [CNT_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ENQ_W-1:0] enq_vld;
    logic [EC_W-1:0]  n_enq;
    logic [EC_W-1:0]  n_acc;
    logic             enq_contig;
    logic [DEQ_W-1:0] occ;
    logic [DC_W-1:0]  n_avail;
    logic [DC_W-1:0]  n_deq;
    logic             avail_contig;
    logic [CNT_W-1:0] free;
    logic             enq_ready;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        for (int i = 0; i < ENQ_W; i++) enq_vld[i] = ib.if_ib_packets[i].valid;
        for (int j = 0; j < DEQ_W; j++) occ[j] = (CNT_W'(j) < count_q);
    end

    popcount_prefix #(.W(ENQ_W)) u_enq_cnt (
        .vld_i    (enq_vld),
        .cnt_o    (n_enq),
        .contig_o (enq_contig)
    );

    // Occupied output lanes always form a prefix; their count is min(DEQ_W, count).
    popcount_prefix #(.W(DEQ_W)) u_deq_cnt (
        .vld_i    (occ),
        .cnt_o    (n_avail),
        .contig_o (avail_contig)
    );

    assign free      = CNT_W'(DEPTH) - count_q;
    assign enq_ready = (free >= CNT_W'(ENQ_W));
    assign n_acc     = enq_ready ? n_enq : '0;
    assign n_deq     = (ib.dispatch_cnt > n_avail) ? n_avail : ib.dispatch_cnt;

    always_comb begin
        mem_d  = mem_q;
        wr_idx = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            if (j < int'(n_deq)) begin
                wr_idx        = head_q[IDX_W-1:0] + IDX_W'(j);
                mem_d[wr_idx] = '0;
            end
        end
        for (int i = 0; i < ENQ_W; i++) begin
            if (i < int'(n_acc)) begin
                wr_idx        = tail_q[IDX_W-1:0] + IDX_W'(i);
                mem_d[wr_idx] = to_dp(ib.if_ib_packets[i]);
            end
        end
        head_d  = head_q + CNT_W'(n_deq);
        tail_d  = tail_q + CNT_W'(n_acc);
        count_d = count_q + CNT_W'(n_acc) - CNT_W'(n_deq);
    end

    always_ff @(posedge clock) begin
        if (reset || ib.squash_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        rd_idx = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            rd_idx                 = head_q[IDX_W-1:0] + IDX_W'(j);
            ib.ib_dp_packets[j]    = mem_q[rd_idx];
            if (!occ[j]) ib.ib_dp_packets[j].valid = 1'b0;
        end
    end

    assign ib.ib_enq_ready = enq_ready;
    assign ib.ib_free      = free;
    assign ib.ib_count     = count_q;
    assign ib.ib_empty     = (count_q == '0);
    assign ib.ib_full      = (count_q == CNT_W'(DEPTH));

    a_enq_prefix: assert property (@(posedge clock) disable iff (reset) enq_contig);
    a_deq_bound:  assert property (@(posedge clock) disable iff (reset || ib.squash_in)
                                   int'(ib.dispatch_cnt) <= int'(n_avail));
    a_cnt_ptrs:   assert property (@(posedge clock) disable iff (reset) count_q == (tail_q - head_q));
    a_occ_prefix: assert property (@(posedge clock) disable iff (reset) avail_contig);

endmodule

// File: doc/insn_buffer_mw.md
Name: insn_buffer_mw

Overview:
- Multi-wide, parametrised instruction FIFO between fetch and dispatch, the superscalar successor of the single-wide buffer.
- Accepts up to ENQ_W packets per cycle from fetch and presents up to DEQ_W oldest packets to dispatch, which retires a variable count per cycle.
- Reports free-slot and occupancy counts so fetch can throttle without combinational paths back into dispatch.
- Squash clears all contents in one cycle.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2*max(ENQ_W, DEQ_W).
- ENQ_W, 2, fetch lanes per cycle; 1..4.
- DEQ_W, 2, dispatch lanes per cycle; 1..4.
- CNT_W, $clog2(DEPTH)+1, width of the count signals (derived, not overridden).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash_in  in  1  flush: empty the buffer.
- if_ib_packets  in  ENQ_W x IF_IB_PACKET  fetch lanes; lane i is valid via its .valid field.
- dispatch_cnt  in  $clog2(DEQ_W+1)  number of head entries consumed this cycle.
- ib_enq_ready  out  1  buffer accepts a full ENQ_W group this cycle.
- ib_free  out  CNT_W  free entries.
- ib_count  out  CNT_W  occupied entries.
- ib_empty  out  1  ib_count == 0.
- ib_full  out  1  ib_count == DEPTH.
- ib_dp_packets  out  DEQ_W x IB_DP_PACKET  oldest entries, lane 0 = head.

Behaviour:
- Reset is synchronous and active-high. clock and reset are the sole timing controls.
- Reset or squash_in at a clock edge:
  - head, tail and count go to 0.
  - All entries are cleared to '0 (valid=0).
  - Resulting outputs: ib_count=0, ib_free=DEPTH, ib_empty=1, ib_full=0, ib_enq_ready=1, all ib_dp_packets lanes zero.
  - Squash has priority over any enqueue or dispatch in the same cycle; both are dropped.
- Enqueue:
  - Fetch lanes must present a contiguous valid prefix (lanes 0..k-1 valid). A hole is a protocol error, flagged by an assertion.
  - n_enq = number of valid lanes.
  - ib_enq_ready = (ib_free >= ENQ_W), computed from registered state only.
  - When ib_enq_ready=1, all n_enq packets are written at tail..tail+n_enq-1 (mod DEPTH) in lane order.
  - When ib_enq_ready=0, the whole group is dropped. No partial acceptance. Fetch holds and replays the group.
- Dequeue:
  - Output lane j is the entry at head+j (mod DEPTH). Lane j's .valid is forced to 0 when j >= ib_count.
  - Outputs are a combinational read of registered storage; there is no dependence on the same-cycle enqueue (no bypass).
  - dispatch_cnt must be <= min(DEQ_W, ib_count); a violation is an assertion error. Implementation clamps to ib_count.
  - Consumed entries are cleared to '0 and head advances by dispatch_cnt (mod DEPTH).
- Simultaneous enqueue and dequeue:
  - count_next = count + n_enq_accepted - dispatch_cnt.
  - Slots freed this cycle are not usable by this cycle's enqueue, because ready is based on start-of-cycle ib_free.
- Pointers:
  - head and tail are log2(DEPTH)+1 bits, with a wrap bit.
  - Index = low bits. Wrap-around is natural modulo DEPTH.
  - count is kept explicitly and checked by assertion against tail-head.
- Latency: a packet enqueued at edge k is visible on ib_dp_packets lane 0 after edge k, at the earliest, if the buffer was empty. Minimum latency is 1 cycle.
- Storage is flops. One write port per enqueue lane and one clear per dequeue lane; their indices never collide because a write never targets an occupied slot.

Decomposition:
- sys_defs package:
  - IF_IB_PACKET and IB_DP_PACKET (existing).
  - `IBUFFER_SZ becomes the DEPTH default.
  - New `FETCH_WIDTH and `DISPATCH_WIDTH defaults for ENQ_W and DEQ_W.
- One sub-module: popcount_prefix, which counts valid lanes and checks the contiguity of the prefix. It is reused by dispatch.
- The rest is a single always_ff for state plus always_comb for next-state and output lanes.

Test Plan:
- Reset, then drive 2 valid lanes for 8 cycles with dispatch_cnt=0 (DEPTH=16, ENQ_W=2) -> ib_count increments by 2 to 16, ib_full=1, ib_enq_ready=0 after the 8th edge. A 9th group is dropped; ib_count stays 16.
- From full, hold a valid group and set dispatch_cnt=2 for one cycle -> ib_count=14. ib_enq_ready rises the next cycle and the replayed group is accepted, giving ib_count=16. FIFO order is preserved on readout.
- Steady state: enqueue 2 and dispatch 2 each cycle for 40 cycles -> ib_count constant. Pointers wrap at least twice, and output sequence numbers are strictly increasing with no loss or duplicate.
- Single entry (ib_count=1) -> lane 0 valid, lane 1 .valid=0. dispatch_cnt=1 gives ib_empty=1 next cycle, with all lanes zero.
- With ib_count=10, squash_in=1 together with valid enqueue and dispatch_cnt=2 -> next cycle ib_count=0, ib_free=16, all lanes zero, enqueued packets discarded.
- Enqueue 1 valid lane (lane 1 invalid) while dispatching 1, at head index 15 -> head wraps to 0, tail advances by 1, ib_count unchanged.
